apb_periph_demux: RTL



---
 rtl/apb_periph_demux.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/apb_periph_demux.sv
// Registered APB 1-to-N demultiplexer with a runtime address map, per-slave enables,
// decode-error response and a per-transfer downstream timeout watchdog.
module apb_periph_demux #(
    parameter int NB_SLAVE       = 3,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i,
    input  logic [NB_SLAVE-1:0]                slave_en_i,
    input  logic                               psel_i,
    input  logic                               penable_i,
    input  logic                               pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]          prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    output logic [NB_SLAVE-1:0]                m_psel_o,
    output logic                               m_penable_o,
    output logic                               m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          m_pwdata_o,
    input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLAVE-1:0]                m_pready_i,
    input  logic [NB_SLAVE-1:0]                m_pslverr_i,
    output logic                               timeout_irq_o,
    input  logic                               irq_clr_i
);

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int SW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DSETUP, DACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            irq_q, irq_d, irq_set;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            sel_ready, sel_err;
    logic [DW-1:0]   sel_rdata;

    // Ascending scan with a found flag gives the lowest index priority on overlaps.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NB_SLAVE; i++) begin
            if (!hit && slave_en_i[i] &&
                (paddr_i >= start_addr_i[i*AW +: AW]) &&
                (paddr_i <= end_addr_i[i*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NB_SLAVE; i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = m_pready_i[i];
                sel_err   = m_pslverr_i[i];
                sel_rdata = m_prdata_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        irq_set = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    rdata_d = '0;
                    if (hit) begin
                        sel_d   = hit_idx;
                        err_d   = 1'b0;
                        state_d = DSETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            DSETUP: begin
                cnt_d   = '0;
                state_d = DACCESS;
            end
            DACCESS: begin
                if (sel_ready) begin
                    err_d   = sel_err;
                    rdata_d = (write_q || sel_err) ? '0 : sel_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        irq_set = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        irq_d = irq_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        m_psel_o = '0;
        for (int unsigned i = 0; i < NB_SLAVE; i++) begin
            m_psel_o[i] = ((state_q == DSETUP) || (state_q == DACCESS)) && (sel_q == SW'(i));
        end
    end

    assign m_penable_o   = (state_q == DACCESS);
    assign m_pwrite_o    = write_q;
    assign m_paddr_o     = addr_q;
    assign m_pwdata_o    = wdata_q;
    assign pready_o      = (state_q == RESP);
    assign pslverr_o     = (state_q == RESP) && err_q;
    assign prdata_o      = (state_q == RESP) ? rdata_q : '0;
    assign timeout_irq_o = irq_q;

endmodule
